// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//
// Round-robin arbiter for four requesters that share one 4-way select mux and
// the resource behind it. It returns a one-hot grant to the owner and drives the
// mux select. A hold-time limit (MAX_HOLD) revokes a grant that has lasted too
// long, so that no single owner can starve the others.
//
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : per-requester request, held high while ownership is wanted
//   gnt     : registered one-hot grant (at most one bit set)
//   sel     : index of the current or last owner; drives the mux select
//   busy    : high while a grant is active
//   timeout : one-cycle pulse when a grant is revoked by the hold limit
// -----------------------------------------------------------------------------
module mux_arbiter #(
   parameter int unsigned MAX_HOLD = 16,  // 0 disables the hold limit
   parameter int unsigned HOLD_W   = 5    // 2**HOLD_W must exceed MAX_HOLD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Last counter value at which the grant is still allowed to continue.
   localparam bit                TO_EN     = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST = TO_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

   state_t            state_q, state_d;
   logic [1:0]        last_q, last_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [3:0]        gnt_q, gnt_d;
   logic [1:0]        sel_q, sel_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;

   logic [1:0]        winner;
   logic [1:0]        cand;
   logic              found;

   // Rotating priority search: last+1, last+2, last+3, then last itself.
   always_comb begin
      winner = last_q;
      cand   = last_q;
      found  = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cand = last_q + 2'(i);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      sel_d      = sel_q;
      busy_d     = busy_q;
      timeout_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            gnt_d  = 4'b0000;
            busy_d = 1'b0;
            if (|req) begin
               gnt_d      = 4'b0001 << winner;
               sel_d      = winner;
               last_d     = winner;
               hold_cnt_d = '0;
               busy_d     = 1'b1;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (!req[last_q]) begin
               // Release takes precedence over a coincident timeout.
               gnt_d   = 4'b0000;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (TO_EN && (hold_cnt_q == HOLD_LAST)) begin
               gnt_d     = 4'b0000;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_q     <= 2'd3;  // gives requester 0 first priority after reset
         hold_cnt_q <= '0;
         gnt_q      <= 4'b0000;
         sel_q      <= 2'd0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;

   logic [3:0] gnt_a, gnt_b;
   logic [1:0] sel_a, sel_b;
   logic       busy_a, busy_b;
   logic       timeout_a, timeout_b;

   // dut_a: default hold limit (16); dut_b: hold limit 4
   mux_arbiter dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt_a),
      .sel     (sel_a),
      .busy    (busy_a),
      .timeout (timeout_a)
   );

   mux_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt_b),
      .sel     (sel_b),
      .busy    (busy_b),
      .timeout (timeout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       to;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_mis = 0;
   int   use_b = 0;

   function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s,
                               input logic b, input logic t);
      exp_t e;
      e.gnt = g; e.sel = s; e.busy = b; e.to = t;
      return e;
   endfunction

   task automatic compare(input string tag);
      exp_t e;
      exp_t o;
      if (sb.size() == 0) begin
         n_cmp++;
         n_mis++;
         $display("FAIL %s: scoreboard empty", tag);
         return;
      end
      e = sb.pop_front();
      if (use_b != 0) o = mk(gnt_b, sel_b, busy_b, timeout_b);
      else            o = mk(gnt_a, sel_a, busy_a, timeout_a);
      $display("t=%0t %s dut=%s req=%b gnt=%b sel=%0d busy=%b to=%b", $time, tag,
               (use_b != 0) ? "b" : "a", req, o.gnt, o.sel, o.busy, o.to);
      n_cmp++;
      assert (o.gnt === e.gnt) else begin
         n_mis++;
         $error("FAIL %s gnt: observed %b expected %b", tag, o.gnt, e.gnt);
      end
      n_cmp++;
      assert (o.sel === e.sel) else begin
         n_mis++;
         $error("FAIL %s sel: observed %0d expected %0d", tag, o.sel, e.sel);
      end
      n_cmp++;
      assert (o.busy === e.busy) else begin
         n_mis++;
         $error("FAIL %s busy: observed %b expected %b", tag, o.busy, e.busy);
      end
      n_cmp++;
      assert (o.to === e.to) else begin
         n_mis++;
         $error("FAIL %s timeout: observed %b expected %b", tag, o.to, e.to);
      end
   endtask

   // Drive req for the next edge, record what that edge must produce, check it.
   task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] s, input logic b, input logic t);
      req = r;
      sb.push_back(mk(g, s, b, t));
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] oh;
      rst_n = 1'b0;
      req   = 4'b1111;
      use_b = 0;

      // Reset with all requests high
      repeat (3) @(posedge clk);
      #1;
      sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
      compare("reset");
      rst_n = 1'b1;
      cyc("reset_first", 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
      cyc("reset_rel",   4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

      // Single requester 2
      for (int i = 0; i < 5; i++)
         cyc("single_hold", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
      cyc("single_drop", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
      cyc("single_idle", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

      // Round-robin 0,1,2,3,0 with one dead cycle between owners
      req = 4'b0000;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << (k % 4);
         cyc("rr_grant", 4'b1111, oh, 2'(k % 4), 1'b1, 1'b0);
         cyc("rr_hold",  4'b1111, oh, 2'(k % 4), 1'b1, 1'b0);
         cyc("rr_hold",  4'b1111, oh, 2'(k % 4), 1'b1, 1'b0);
         cyc("rr_gap",   4'b1111 & ~oh, 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      end

      // Reset mid-grant: last owner was 0, so requester 3 wins alone
      cyc("mid_grant", 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
      cyc("mid_hold",  4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
      rst_n = 1'b0;
      #2;
      sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
      compare("async_reset");
      #1;
      rst_n = 1'b1;
      cyc("after_reset", 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);

      // Timeout behaviour on the MAX_HOLD=4 instance
      req = 4'b0000;
      do_reset();
      use_b = 1;
      for (int i = 0; i < 4; i++)
         cyc("to_own0", 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
      cyc("to_pulse0", 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++)
         cyc("to_own1", 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
      cyc("to_pulse1", 4'b0011, 4'b0000, 2'd1, 1'b0, 1'b1);
      cyc("to_back0", 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
      // only requester 0 left: re-granted after the dead cycle
      for (int i = 0; i < 3; i++)
         cyc("solo_own", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
      cyc("solo_pulse", 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1);
      cyc("solo_regrant", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
      // release coincides with hold_cnt == MAX_HOLD-1: release wins
      for (int i = 0; i < 3; i++)
         cyc("rel_to_hold", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
      cyc("rel_to_edge", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      cyc("rel_to_after", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
